// File: rtl/writeback_queue.sv
// writeback_queue: 5-lane commit compaction FIFO feeding 2 register-file write ports (optional same-cycle bypass under WBQ_BYPASS_EN)
module writeback_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [4:0]             in_valid,
  input  logic [4:0][4:0]        in_dst,
  input  logic [4:0][DATA_W-1:0] in_data,
  output logic                   in_ready,
  output logic [1:0]             wb_valid,
  output logic [1:0][4:0]        wb_dst,
  output logic [1:0][DATA_W-1:0] wb_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [4:0]        mem_dst  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [4:0]        cmp_dst  [7];
  logic [DATA_W-1:0] cmp_data [7];
  logic [2:0]        npush, byp, nenq;
  logic [1:0]        npop;
  logic              accept;
  assign in_ready = count <= CW'(DEPTH - 5);
  assign accept   = in_ready & ~flush & ~reset & |in_valid;
  assign npop     = count >= CW'(2) ? 2'd2 : count[1:0];
  // compact surviving lanes (valid, dst != x0) in lane order; slots 5-6 pad the bypass offset
  always_comb begin
    npush = '0;
    for (int i = 0; i < 7; i++) begin
      cmp_dst[i]  = '0;
      cmp_data[i] = '0;
    end
    for (int i = 0; i < 5; i++)
      if (in_valid[i] && in_dst[i] != '0) begin
        cmp_dst[npush]  = in_dst[i];
        cmp_data[npush] = in_data[i];
        npush = npush + 3'd1;
      end
  end
  // port 0 is always the older write; on equal dst the register file must let port 1 win
  always_comb begin
    byp        = '0;
    wb_valid   = {count >= CW'(2), count != '0};
    wb_dst[0]  = mem_dst[head];
    wb_dst[1]  = mem_dst[head + AW'(1)];
    wb_data[0] = mem_data[head];
    wb_data[1] = mem_data[head + AW'(1)];
`ifdef WBQ_BYPASS_EN
    if (count == '0 && accept) begin
      byp        = npush >= 3'd2 ? 3'd2 : npush;
      wb_valid   = {npush >= 3'd2, npush != '0};
      wb_dst[0]  = cmp_dst[0];
      wb_dst[1]  = cmp_dst[1];
      wb_data[0] = cmp_data[0];
      wb_data[1] = cmp_data[1];
    end
`endif
    nenq = accept ? npush - byp : '0;
  end
  // pointer and occupancy update; flush empties the queue after the current wb cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + AW'(npop);
      tail  <= tail + AW'(nenq);
      count <= count + CW'(nenq) - CW'(npop);
    end
  // entry storage, written at the tail with the non-bypassed survivors
  always_ff @(posedge clk)
    for (int j = 0; j < 5; j++)
      if (3'(j) < nenq) begin
        mem_dst[tail + AW'(j)]  <= cmp_dst[3'(j) + byp];
        mem_data[tail + AW'(j)] <= cmp_data[3'(j) + byp];
      end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: randomized scoreboard bench for writeback_queue (default build, DEPTH 8)
module tb_writeback_queue;
  localparam int DEPTH = 8;
  typedef struct packed {logic [4:0] dst; logic [63:0] data;} ent_t;
  typedef struct packed {logic [1:0] nv; logic rdy;} cyc_t;
  logic              clk, reset, flush, in_ready;
  logic [4:0]        in_valid;
  logic [4:0][4:0]   in_dst;
  logic [4:0][63:0]  in_data;
  logic [1:0]        wb_valid;
  logic [1:0][4:0]   wb_dst;
  logic [1:0][63:0]  wb_data;
  ent_t exp_q[$];
  cyc_t cyc_q[$];
  int   occ, errors, checks;
  logic acc;
  logic [4:0][4:0]  d;
  logic [4:0][63:0] x;
  writeback_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_dst(in_dst),
    .in_data(in_data), .in_ready(in_ready), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // one cycle of stimulus; the queue model is just the list of pending writes
  task automatic drive(input logic [4:0] v, input logic [4:0][4:0] dd, input logic [4:0][63:0] xx,
                       input logic fl, output logic a);
    int np, pushed;
    logic rdy;
    @(negedge clk);
    in_valid = v; in_dst = dd; in_data = xx; flush = fl;
    rdy = (DEPTH - occ) >= 5;
    a = rdy && !fl && (v != 0);
    np = occ < 2 ? occ : 2;
    cyc_q.push_back('{nv: 2'(np), rdy: rdy});
    if (fl) begin
      while (exp_q.size() > np) void'(exp_q.pop_back());
      occ = 0;
    end else begin
      pushed = 0;
      if (a)
        for (int i = 0; i < 5; i++)
          if (v[i] && dd[i] != 0) begin
            exp_q.push_back('{dst: dd[i], data: xx[i]});
            pushed++;
          end
      occ = occ + pushed - np;
    end
  endtask
  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) drive(5'b0, '0, '0, 1'b0, a);
  endtask
  // monitor: late in each cycle, compare presented writes against the scoreboard
  initial begin
    cyc_t c;
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("wb_valid", 64'(wb_valid), c.nv == 0 ? 64'd0 : c.nv == 1 ? 64'd1 : 64'd3);
        chk("in_ready", 64'(in_ready), 64'(c.rdy));
        for (int p = 0; p < 2; p++)
          if (p < c.nv) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 64'd1, 64'd0);
            else begin
              e = exp_q.pop_front();
              chk($sformatf("wb_dst%0d", p), 64'(wb_dst[p]), 64'(e.dst));
              chk($sformatf("wb_data%0d", p), wb_data[p], e.data);
            end
          end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    errors = 0; checks = 0; occ = 0;
    reset = 1; flush = 0; in_valid = 0; in_dst = '0; in_data = '0;
    #1;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 0;
    d = '0; x = '0;
    d[0] = 1; d[1] = 2; d[2] = 3; x[0] = 64'hA; x[1] = 64'hB; x[2] = 64'hC;
    drive(5'b00111, d, x, 0, acc);
    idle(3);
    d = '0; x = '0;
    d[1] = 0; d[4] = 5; x[1] = 64'hDEAD; x[4] = 64'h1000;
    drive(5'b10010, d, x, 0, acc);
    idle(3);
    for (int i = 0; i < 5; i++) begin d[i] = 5'(10 + i); x[i] = 64'(100 + i); end
    drive(5'b11111, d, x, 0, acc);
    chk("grp1_accept", 64'(acc), 64'd1);
    for (int i = 0; i < 5; i++) begin d[i] = 5'(20 + i); x[i] = 64'(200 + i); end
    acc = 0;
    for (int k = 0; k < 6 && !acc; k++) drive(5'b11111, d, x, 0, acc);
    chk("grp2_accept", 64'(acc), 64'd1);
    chk("occ_before_flush", 64'(occ), 64'd6);
    for (int i = 0; i < 5; i++) begin d[i] = 5'(1 + i); x[i] = 64'(300 + i); end
    drive(5'b11111, d, x, 1, acc);
    idle(2);
    d[0] = 7; d[1] = 8; d[2] = 0; d[3] = 9; d[4] = 10;
    drive(5'b11111, d, x, 0, acc);
    @(negedge clk);
    #1;
    reset = 1;
    in_valid = 0;
    #1;
    chk("midreset_wb_valid", 64'(wb_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    cyc_q.delete();
    occ = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("postreset_wb_valid", 64'(wb_valid), 64'd0);
    chk("postreset_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 5; i++) begin
        d[i] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        x[i] = {$urandom, $urandom};
      end
      drive(($urandom_range(5) == 0) ? 5'b0 : 5'($urandom), d, x, $urandom_range(24) == 0, acc);
    end
    for (int k = 0; k < 20 && occ > 0; k++) idle(1);
    idle(1);
    @(negedge clk);
    #5;
    chk("drained_entries", 64'(exp_q.size()), 64'd0);
    chk("drained_cycles", 64'(cyc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 8.
REQ-002 Parameter DATA_W, default 64, result width (word_t).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all queued results.
REQ-006 in_valid  input  5  per-lane valid; lanes 0-3 are ALU commits, lane 4 is the branch commit.
REQ-007 in_dst  input  5x5  per-lane destination register index.
REQ-008 in_data  input  5xDATA_W  per-lane result.
REQ-009 in_ready  output  1  queue accepts the whole lane group this cycle.
REQ-010 wb_valid  output  2  per register-file write port valid.
REQ-011 wb_dst  output  2x5  per-port destination index.
REQ-012 wb_data  output  2xDATA_W  per-port write data.

Function
REQ-013 The block SHALL hold pending register writes in a circular FIFO with head pointer, tail pointer and a count register of width clog2(DEPTH)+1.
REQ-014 in_ready SHALL be 1 exactly when DEPTH - count >= 5, computed from registered count only, with no dependence on the same-cycle drain.
REQ-015 A group SHALL be accepted when in_ready is 1, flush is 0 and any in_valid bit is 1; an accept with in_ready 0 SHALL NOT occur, and the input is ignored.
REQ-016 An accepted group SHALL be compacted in lane order 0..4, each valid lane with in_dst != 0 taking the next tail slot; lanes with in_dst == 0 SHALL be dropped.
REQ-017 Each cycle the two oldest entries SHALL drive wb port 0 (oldest) and port 1, with wb_valid reflecting count (0, 1 or 2+ entries); those entries SHALL be popped at the clock edge.
REQ-018 Pointers SHALL wrap modulo DEPTH; count_next = count + pushed - popped, never exceeding DEPTH or going below 0.
REQ-019 Push and pop in the same cycle SHALL both take effect; a full queue draining 2 while 0 are accepted SHALL produce count DEPTH-2.
REQ-020 Without bypass, results SHALL appear on wb exactly 1 cycle after acceptance.
REQ-021 flush SHALL set count to 0 and head = tail at the next edge and suppress that cycle's push; wb outputs in the flush cycle are still driven and written.
REQ-022 When two queued entries target the same dst, they SHALL retire in program order; port 1 wins if both ports write in one cycle, and this rule is documented for the register file.

Reset
REQ-023 On reset assertion, count, head and tail SHALL clear to 0 immediately, independent of clk.
REQ-024 During reset, wb_valid SHALL be 0 and in_ready SHALL be 1; entry storage needs no reset.
REQ-025 Reset asserted mid-operation SHALL discard all pending entries with no partial write.

Configuration
REQ-026 Macro WBQ_BYPASS_EN: when defined, if count == 0 at acceptance, the first up to 2 surviving lanes SHALL drive wb ports combinationally in the same cycle and only the remainder enqueue.
REQ-027 With WBQ_BYPASS_EN defined, flush SHALL suppress bypass as well.
REQ-028 Without WBQ_BYPASS_EN, REQ-020 latency applies unconditionally and no input-to-output combinational path SHALL exist.

Verification
REQ-029 Empty queue, lanes 0,1,2 valid, dst 1/2/3, data 0xA/0xB/0xC -> next cycle wb {1:0xA, 2:0xB}, following cycle wb0 {3:0xC}, wb_valid 01, then idle.
REQ-030 Lane 1 dst 0 plus lane 4 dst 5 data 0x1000 -> only dst 5 written; the x0 entry is never seen on wb.
REQ-031 DEPTH 8, two back-to-back 5-lane groups -> second group blocked (count 5, in_ready 0) until count <= 3; all 10 writes retire in order with no loss.
REQ-032 Count 6 with flush pulsed while a valid group is presented -> next cycle count 0, wb_valid 00, group discarded.
REQ-033 Reset asserted between edges with count 4 -> outputs clear immediately; after release, in_ready 1 and wb_valid 00.
REQ-034 WBQ_BYPASS_EN, empty queue, lanes 0-3 valid dst 1-4 -> same cycle wb {1,2}; next cycle wb {3,4}.
